// File: rtl/de0_nano_led_sequencer.sv
// de0_nano_led_sequencer
// Drives the 8-bit LED PIO with an autonomous pattern animation so the CPU only
// configures it. The sequencer shares the clock domain of the Nios/host interconnect.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave (CPU side). Writes occur when
//   write_n, writedata,   chipselect=1 and write_n=0.
//   readdata              Reads are combinational with zero wait states.
//   pio_chipselect,       master-side write port into the LED PIO; one-cycle
//   pio_write_n,          strobes carrying {zeros, pattern}
//   pio_address,
//   pio_writedata
//   busy                  high while enabled (RUN or STROBE)
//
// Register map: 0 CTRL {mode[2:1], enable[0]}, 1 PERIOD, 2 PATTERN,
//               3 STATUS {busy[17], dir[16], step_count[15:0]} (read-only)
module de0_nano_led_sequencer #(
    parameter int unsigned         LED_W        = 8,
    parameter int unsigned         PERIOD_W     = 32,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = 32'd49999999,
    parameter logic [LED_W-1:0]    SEED_RESET   = 8'h01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [1:0]  pio_address,
    output logic [31:0] pio_writedata,
    output logic        busy
);

    localparam int unsigned PadW = 32 - LED_W;

    localparam logic [1:0] ModeStatic = 2'd0;
    localparam logic [1:0] ModeRotate = 2'd1;
    localparam logic [1:0] ModeBounce = 2'd2;
    localparam logic [1:0] ModeCount  = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StStrobe} state_e;

    state_e              state_q;
    logic                enable_q;
    logic [1:0]          mode_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] prescaler_q;
    logic [LED_W-1:0]    pattern_q;
    logic                dir_q;
    logic [15:0]         step_count_q;

    logic             wr, ctrl_wr, period_wr, pattern_wr;
    logic             enable_next;
    logic [LED_W-1:0] step_pattern;
    logic             step_dir;
    logic [LED_W-1:0] host_pattern;

    assign wr           = chipselect & ~write_n;
    assign ctrl_wr      = wr && (address == 2'd0);
    assign period_wr    = wr && (address == 2'd1);
    assign pattern_wr   = wr && (address == 2'd2);
    assign enable_next  = ctrl_wr ? writedata[0] : enable_q;
    assign host_pattern = writedata[LED_W-1:0];

    assign pio_address = 2'b00;
    assign busy        = (state_q != StIdle);

    // Pattern and direction that the next step would produce in the current mode.
    always_comb begin
        step_pattern = pattern_q;
        step_dir     = dir_q;
        unique case (mode_q)
            ModeRotate: step_pattern = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
            ModeBounce: begin
                if (!dir_q) begin
                    step_pattern = pattern_q << 1;
                    if (step_pattern[LED_W-1]) step_dir = 1'b1;
                end else begin
                    step_pattern = pattern_q >> 1;
                    if (step_pattern[0]) step_dir = 1'b0;
                end
            end
            ModeCount:  step_pattern = pattern_q + {{(LED_W-1){1'b0}}, 1'b1};
            default:    ;  // static: pattern unchanged
        endcase
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {29'd0, mode_q, enable_q};
            2'd1:    readdata[PERIOD_W-1:0] = period_q;
            2'd2:    readdata[LED_W-1:0] = pattern_q;
            default: readdata = {14'd0, busy, dir_q, step_count_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            enable_q       <= 1'b0;
            mode_q         <= ModeStatic;
            period_q       <= PERIOD_RESET;
            prescaler_q    <= '0;
            pattern_q      <= SEED_RESET;
            dir_q          <= 1'b0;
            step_count_q   <= 16'd0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= 32'd0;
        end else begin
            // Strobes last exactly one cycle unless re-armed below.
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;

            if (ctrl_wr) begin
                enable_q <= writedata[0];
                mode_q   <= writedata[2:1];
            end
            if (period_wr) period_q <= writedata[PERIOD_W-1:0];
            if (pattern_wr) begin
                pattern_q <= host_pattern;
                dir_q     <= 1'b0;
            end

            if (state_q == StIdle) begin
                prescaler_q <= '0;
                if (ctrl_wr && writedata[0]) begin
                    // Enabling pushes the current pattern straight away.
                    state_q        <= StStrobe;
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_writedata  <= {{PadW{1'b0}}, pattern_q};
                    step_count_q   <= step_count_q + 16'd1;
                end
            end else if (!enable_next) begin
                // Disable wins over any step due this cycle; a strobe already
                // on the bus has completed by the time we leave STROBE.
                state_q     <= StIdle;
                prescaler_q <= '0;
            end else if (pattern_wr) begin
                // Host value wins over a coincident step, even in static mode.
                state_q        <= StStrobe;
                prescaler_q    <= '0;
                pio_chipselect <= 1'b1;
                pio_write_n    <= 1'b0;
                pio_writedata  <= {{PadW{1'b0}}, host_pattern};
                step_count_q   <= step_count_q + 16'd1;
            end else if (state_q == StStrobe) begin
                state_q <= StRun;
            end else if (period_wr) begin
                prescaler_q <= '0;
            end else if (mode_q != ModeStatic) begin
                if (prescaler_q == period_q) begin
                    state_q        <= StStrobe;
                    prescaler_q    <= '0;
                    pattern_q      <= step_pattern;
                    dir_q          <= step_dir;
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_writedata  <= {{PadW{1'b0}}, step_pattern};
                    step_count_q   <= step_count_q + 16'd1;
                end else begin
                    prescaler_q <= prescaler_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_de0_nano_led_sequencer.sv
// Directed bench for de0_nano_led_sequencer: register reset values, rotate,
// bounce, count and static modes, host pattern on a terminal tick, disable
// during a strobe and asynchronous reset in the middle of a strobe.
module tb_de0_nano_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [1:0]  pio_address;
    logic [31:0] pio_writedata;
    logic        busy;

    de0_nano_led_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_address    (pio_address),
        .pio_writedata  (pio_writedata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  data;
        logic [31:0] status;
    } strobe_t;

    strobe_t q[$];

    // Record every PIO write strobe shortly after the edge that launched it.
    always @(posedge clk) begin
        #1;
        if (pio_chipselect && !pio_write_n)
            q.push_back('{cyc, pio_writedata[7:0], readdata});
    end

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        wr_cyc     = cyc;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd3;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
        @(negedge clk);
        address = 2'd3;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && q.size() < n; i++) @(negedge clk);
        if (q.size() < n) check({tag, " timeout"}, q.size(), n);
    endtask

    task automatic check_strobe(input string tag, input int idx, input int exp_cyc,
                                input logic [7:0] exp_data);
        if (idx < q.size()) begin
            check({tag, " data"}, {24'd0, q[idx].data}, {24'd0, exp_data});
            check({tag, " cycle"}, q[idx].cyc, exp_cyc);
        end else begin
            check({tag, " missing"}, q.size(), idx + 1);
        end
    endtask

    logic [7:0] rot_exp [9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bnc_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic       bnc_dir [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0] cnt_exp [4]  = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    initial begin
        int s;
        logic [15:0] d;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd3;
        writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        rd_check("rst ctrl", 2'd0, 32'd0);
        rd_check("rst period", 2'd1, 32'd49999999);
        rd_check("rst pattern", 2'd2, 32'h01);
        rd_check("rst status", 2'd3, 32'd0);
        check("rst pio_cs", {31'd0, pio_chipselect}, 32'd0);
        check("rst pio_wn", {31'd0, pio_write_n}, 32'd1);
        check("rst pio_wd", pio_writedata, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);

        // Rotate, PERIOD=3
        cpu_write(2'd1, 32'd3);
        cpu_write(2'd0, 32'b011);
        s = wr_cyc + 1;
        wait_strobes(9, 80, "rot");
        for (int i = 0; i < 9; i++) check_strobe("rot", i, s + 5 * i, rot_exp[i]);
        for (int i = 2; i < 9; i++) begin
            if (i < q.size()) begin
                d = q[i].status[15:0] - q[i-1].status[15:0];
                check("rot step_count inc", {16'd0, d}, 32'd1);
            end
        end
        cpu_write(2'd0, 32'd0);
        repeat (10) @(negedge clk);
        check("rot off busy", {31'd0, busy}, 32'd0);
        q.delete();

        // Bounce, seed 0x01, PERIOD=0
        cpu_write(2'd2, 32'h01);
        cpu_write(2'd1, 32'd0);
        cpu_write(2'd0, 32'b101);
        s = wr_cyc + 1;
        wait_strobes(16, 60, "bnc");
        for (int i = 0; i < 16; i++) check_strobe("bnc", i, s + 2 * i, bnc_exp[i]);
        for (int i = 1; i < 16; i++)
            if (i < q.size()) check("bnc dir", {31'd0, q[i].status[16]}, {31'd0, bnc_dir[i]});
        if (q.size() > 3) check("bnc status busy", {31'd0, q[3].status[17]}, 32'd1);
        cpu_write(2'd0, 32'd0);
        repeat (10) @(negedge clk);
        q.delete();

        // Count, seed 0xFE, PERIOD=1
        cpu_write(2'd2, 32'hFE);
        cpu_write(2'd1, 32'd1);
        cpu_write(2'd0, 32'b111);
        s = wr_cyc + 1;
        wait_strobes(4, 40, "cnt");
        for (int i = 0; i < 4; i++) check_strobe("cnt", i, s + 3 * i, cnt_exp[i]);
        cpu_write(2'd0, 32'd0);
        repeat (10) @(negedge clk);
        q.delete();

        // Static, enabled: quiet until the host writes PATTERN
        cpu_write(2'd0, 32'b001);
        repeat (5) @(negedge clk);
        q.delete();
        repeat (100) @(negedge clk);
        check("static quiet", q.size(), 32'd0);
        check("static busy", {31'd0, busy}, 32'd1);
        cpu_write(2'd2, 32'hA5);
        s = wr_cyc + 1;
        repeat (10) @(negedge clk);
        check("static one strobe", q.size(), 32'd1);
        check_strobe("static a5", 0, s, 8'hA5);
        cpu_write(2'd0, 32'd0);
        repeat (5) @(negedge clk);
        q.delete();

        // PATTERN written on the terminal prescaler cycle
        cpu_write(2'd2, 32'h01);
        cpu_write(2'd1, 32'd3);
        cpu_write(2'd0, 32'b011);
        s = wr_cyc + 1;
        while (cyc < s + 4) @(negedge clk);
        cpu_write(2'd2, 32'h3C);
        wait_strobes(3, 30, "term");
        check_strobe("term first", 0, s, 8'h01);
        check_strobe("term host", 1, s + 5, 8'h3C);
        check_strobe("term next", 2, s + 10, 8'h78);

        // Disable while the 0x78 strobe is on the bus
        while (cyc < s + 10) @(negedge clk);
        check("dis mid strobe cs", {31'd0, pio_chipselect}, 32'd1);
        cpu_write(2'd0, 32'b010);
        repeat (30) @(negedge clk);
        check("dis no more strobes", q.size(), 32'd3);
        check("dis busy", {31'd0, busy}, 32'd0);
        q.delete();

        // Asynchronous reset in the middle of a strobe
        cpu_write(2'd1, 32'd0);
        cpu_write(2'd0, 32'b011);
        check("ar pre cs", {31'd0, pio_chipselect}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar pio_cs", {31'd0, pio_chipselect}, 32'd0);
        check("ar pio_wn", {31'd0, pio_write_n}, 32'd1);
        check("ar pio_wd", pio_writedata, 32'd0);
        check("ar busy", {31'd0, busy}, 32'd0);
        check("ar status", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_check("ar period", 2'd1, 32'd49999999);
        rd_check("ar pattern", 2'd2, 32'h01);
        rd_check("ar ctrl", 2'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
